// File: rtl/reg64_loader.sv
// Byte-stream loader for a 64-bit holding register: assembles bytes LSB-first,
// writes the word with a one-cycle En pulse, and reads it back on request.
module reg64_loader #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             start_read,
  output logic [WIDTH-1:0] reg_in,
  output logic             reg_En,
  output logic             reg_Read,
  input  logic [WIDTH-1:0] reg_out,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             match,
  output logic             busy
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ1 = 2'd2;
  localparam logic [1:0] READ2 = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    byte_cnt;
  logic [WIDTH-1:0] shift_word;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] last_wr;
  logic             read_pend;
  logic             xfer;
  logic             word_done;
  logic             read_go;

  // NOTE: byte_ready is gated by Rst combinationally so it reads 0 throughout
  // reset, not just from the first edge after Rst rises.
  assign byte_ready = !Rst && (state == IDLE) && !(read_pend && byte_cnt == '0);
  assign xfer       = byte_valid && byte_ready;
  assign word_done  = xfer && (byte_cnt == LAST_BYTE);
  assign read_go    = (state == IDLE) && read_pend && (byte_cnt == '0);

  assign reg_En   = (state == WRITE);
  assign reg_Read = (state == READ1) || (state == READ2);
  assign busy     = (state != IDLE) || (byte_cnt != '0) || read_pend;

  // Word as it will look once the byte on the bus lands in its lane.
  always_comb begin
    word_next = shift_word;
    word_next[{byte_cnt, 3'b000} +: 8] = byte_in;
  end

  // NOTE: all state uses non-blocking assignments so every branch sees the
  // pre-edge values of state, byte_cnt and read_pend.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      shift_word <= '0;
      last_wr    <= '0;
      read_pend  <= 1'b0;
      reg_in     <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      match      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;

      // A new request wins over the clear, so a pulse during service queues one more read.
      if (start_read)   read_pend <= 1'b1;
      else if (read_go) read_pend <= 1'b0;

      if (xfer) begin
        shift_word <= word_next;
        byte_cnt   <= word_done ? '0 : byte_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (word_done) begin
            reg_in  <= word_next;
            last_wr <= word_next;
            state   <= WRITE;
          end else if (read_go) begin
            state <= READ1;
          end
        end
        WRITE: state <= IDLE;
        READ1: state <= READ2;
        READ2: begin
          rd_data  <= reg_out;
          match    <= (reg_out == last_wr);
          rd_valid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg64_loader.sv
// Self-checking bench for reg64_loader: directed timing checks plus randomized
// words and reads scored against a byte-level reference model.
module tb_reg64_loader;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        start_read;
  logic [63:0] reg_in;
  logic        reg_En;
  logic        reg_Read;
  logic [63:0] reg_out;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        match;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Behavioural holding register: captures on En, drives out while Read.
  logic [63:0] model_reg;
  logic        force_zero;
  logic [63:0] ref_last_wr;

  logic [63:0] en_q[$];
  logic [63:0] rd_q[$];
  logic        match_q[$];

  always #5 Clk = ~Clk;

  reg64_loader #(.WIDTH(64)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .start_read (start_read),
    .reg_in     (reg_in),
    .reg_En     (reg_En),
    .reg_Read   (reg_Read),
    .reg_out    (reg_out),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .match      (match),
    .busy       (busy)
  );

  always @(posedge Clk) if (reg_En) model_reg <= reg_in;
  assign reg_out = (reg_Read && !force_zero) ? model_reg : 64'h0;

  always @(negedge Clk) begin
    if (!Rst) begin
      if (reg_En) en_q.push_back(reg_in);
      if (rd_valid) begin
        rd_q.push_back(rd_data);
        match_q.push_back(match);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int waits);
    byte_in    = b;
    byte_valid = 1'b1;
    waits      = 0;
    while (!byte_ready && waits < 100) begin
      @(negedge Clk);
      waits++;
    end
    if (waits >= 100) check("ready_timeout", 64'd0, 64'd1);
    @(negedge Clk);
  endtask

  // Sends w LSB byte first; returns at the negedge just after the last transfer.
  task automatic send_word(input logic [63:0] w, input int max_gap);
    int waits;
    for (int k = 0; k < 8; k++) begin
      if (max_gap > 0) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge Clk);
      end
      send_byte(w[8*k +: 8], waits);
    end
    byte_valid  = 1'b0;
    ref_last_wr = w;
  endtask

  task automatic pulse_read();
    start_read = 1'b1;
    @(negedge Clk);
    start_read = 1'b0;
  endtask

  // Entered at the negedge where the loader sits in IDLE with a read pending.
  task automatic expect_read(input logic [63:0] exp_data, input logic exp_match);
    check("rd_pend_read", reg_Read, 0);
    check("rd_pend_ready", byte_ready, 0);
    @(negedge Clk);
    check("rd_read1", reg_Read, 1);
    check("rd_read1_valid", rd_valid, 0);
    @(negedge Clk);
    check("rd_read2", reg_Read, 1);
    check("rd_read2_valid", rd_valid, 0);
    @(negedge Clk);
    check("rd_read_done", reg_Read, 0);
    check("rd_valid", rd_valid, 1);
    check("rd_data", rd_data, exp_data);
    check("rd_match", match, exp_match);
    @(negedge Clk);
    check("rd_valid_pulse", rd_valid, 0);
    check("rd_match_hold", match, exp_match);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    logic [63:0] d;
    int          waits;
    int          mode;
    int          k;
    int          n;
    logic        fz;
    logic [63:0] exp_en[$];
    logic [63:0] exp_rd[$];
    logic        exp_m[$];

    Rst = 1'b1; byte_valid = 1'b1; byte_in = 8'hAA; start_read = 1'b0;
    force_zero = 1'b0; model_reg = 64'h0; ref_last_wr = 64'h0;

    // Reset with byte_valid asserted
    repeat (3) begin
      @(negedge Clk);
      check("rst_ready", byte_ready, 0);
      check("rst_outs", {reg_En, reg_Read, rd_valid, match, busy}, 0);
      check("rst_reg_in", reg_in, 0);
      check("rst_rd_data", rd_data, 0);
    end
    Rst = 1'b0;
    #1;
    check("rel_ready", byte_ready, 1);
    byte_valid = 1'b0;

    // Single word write and its En timing
    @(negedge Clk);
    send_word(64'h0000_0000_0000_0059, 0);
    check("wr_en", reg_En, 1);
    check("wr_ready_low", byte_ready, 0);
    check("wr_reg_in", reg_in, 64'h59);
    @(negedge Clk);
    check("wr_en_pulse", reg_En, 0);
    check("wr_ready_back", byte_ready, 1);

    // Readback with match
    send_word(64'h8877_6655_4433_2211, 0);
    @(negedge Clk);
    pulse_read();
    expect_read(64'h8877_6655_4433_2211, 1'b1);

    // Mismatch: register output forced to zero
    send_word(64'h59, 0);
    @(negedge Clk);
    force_zero = 1'b1;
    pulse_read();
    expect_read(64'h0, 1'b0);
    force_zero = 1'b0;

    // Read requested mid-word: bytes keep flowing, write precedes read
    w = 64'hC3B2_A190_7F6E_5D4C;
    for (int j = 0; j < 3; j++) send_byte(w[8*j +: 8], waits);
    start_read = 1'b1;
    send_byte(w[31:24], waits);
    start_read = 1'b0;
    check("partial_wait3", waits, 0);
    for (int j = 4; j < 8; j++) begin
      send_byte(w[8*j +: 8], waits);
      check("partial_wait", waits, 0);
    end
    byte_valid  = 1'b0;
    ref_last_wr = w;
    check("partial_en", reg_En, 1);
    check("partial_no_read", reg_Read, 0);
    check("partial_reg_in", reg_in, w);
    @(negedge Clk);
    expect_read(w, 1'b1);

    // Reset mid-word discards partial bytes
    for (int j = 0; j < 5; j++) send_byte(8'hA1 + 8'(j), waits);
    byte_valid = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check("midrst_ready", byte_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_reg_in", reg_in, 0);
    @(negedge Clk);
    Rst = 1'b0;
    ref_last_wr = 64'h0;
    @(negedge Clk);
    send_word(64'h8877_6655_4433_2211, 0);
    check("midrst_en", reg_En, 1);
    check("midrst_word", reg_in, 64'h8877_6655_4433_2211);
    @(negedge Clk);
    pulse_read();
    expect_read(64'h8877_6655_4433_2211, 1'b1);

    // Randomized words, gaps and read requests against the reference model
    en_q.delete(); rd_q.delete(); match_q.delete();
    for (int it = 0; it < 24; it++) begin
      w    = {$urandom, $urandom};
      mode = $urandom_range(0, 2);
      k    = $urandom_range(0, 7);
      fz   = ($urandom_range(0, 3) == 0);
      force_zero = fz;
      exp_en.delete(); exp_rd.delete(); exp_m.delete();
      if (mode == 2) begin
        // Read issued while idle: served before the new word, returns the old one
        pulse_read();
        d = fz ? 64'h0 : ref_last_wr;
        exp_rd.push_back(d);
        exp_m.push_back(d == ref_last_wr);
      end
      for (int j = 0; j < 8; j++) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge Clk);
        if (mode == 1 && j == k) start_read = 1'b1;
        send_byte(w[8*j +: 8], waits);
        start_read = 1'b0;
      end
      byte_valid  = 1'b0;
      ref_last_wr = w;
      exp_en.push_back(w);
      if (mode == 1) begin
        // Read issued mid-word: the write goes first, so the new word comes back
        d = fz ? 64'h0 : w;
        exp_rd.push_back(d);
        exp_m.push_back(d == w);
      end
      n = 0;
      while (busy && n < 50) begin
        @(negedge Clk);
        n++;
      end
      check("rnd_idle_timeout", n >= 50, 0);
      @(negedge Clk);
      check("rnd_en_count", en_q.size(), exp_en.size());
      check("rnd_rd_count", rd_q.size(), exp_rd.size());
      while (en_q.size() > 0 && exp_en.size() > 0)
        check("rnd_wr_word", en_q.pop_front(), exp_en.pop_front());
      while (rd_q.size() > 0 && exp_rd.size() > 0) begin
        check("rnd_rd_data", rd_q.pop_front(), exp_rd.pop_front());
        check("rnd_match", match_q.pop_front(), exp_m.pop_front());
      end
      en_q.delete(); rd_q.delete(); match_q.delete();
    end
    force_zero = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
